// File: rtl/unidade_busca.sv
// rtl/unidade_busca.sv - three-state instruction fetch unit (BUSCA/CAPTURA/EXECUTA) feeding the decoder.
// Optional single-step input passo is enabled with macro UNIDADE_BUSCA_PASSO_EN.
module unidade_busca #(
  parameter int                     LARGURA_PC      = 6,
  parameter int                     LARGURA_INSTR   = 17,
  parameter int                     ULTIMO_ENDERECO = 63,
  parameter logic [LARGURA_INSTR-1:0] BOLHA         = 17'h0A000
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     Write_Pc,
  input  logic [LARGURA_PC-1:0]    endereco_Salto,
  input  logic                     clear,
  input  logic                     halt,
`ifdef UNIDADE_BUSCA_PASSO_EN
  input  logic                     passo,
`endif
  input  logic [LARGURA_INSTR-1:0] dado_rom,
  output logic [LARGURA_PC-1:0]    endereco_rom,
  output logic [LARGURA_INSTR-1:0] codigo_maquina,
  output logic                     instr_valida,
  output logic [LARGURA_PC-1:0]    pc
);

  localparam logic [LARGURA_PC-1:0] ULTIMO = LARGURA_PC'(ULTIMO_ENDERECO);
  localparam logic [LARGURA_PC-1:0] UM     = LARGURA_PC'(1);

  typedef enum logic [1:0] {
    BUSCA   = 2'd0,
    CAPTURA = 2'd1,
    EXECUTA = 2'd2
  } estado_t;

  estado_t                  estado_q, estado_d;
  logic [LARGURA_PC-1:0]    pc_q, pc_d;
  logic [LARGURA_INSTR-1:0] ir_q, ir_d;
  logic                     valida_q, valida_d;
  logic                     avanca;

`ifdef UNIDADE_BUSCA_PASSO_EN
  assign avanca = ~halt & passo;
`else
  assign avanca = ~halt;
`endif

  always_comb begin
    estado_d = estado_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    valida_d = 1'b0;
    case (estado_q)
      BUSCA: begin
        if (avanca) estado_d = CAPTURA;
      end
      CAPTURA: begin
        ir_d     = dado_rom;
        valida_d = 1'b1;
        estado_d = EXECUTA;
      end
      EXECUTA: begin
        estado_d = BUSCA;
        // Out-of-range targets and increment past the last address both land on 0.
        if (clear) begin
          pc_d = '0;
        end else if (Write_Pc) begin
          pc_d = (endereco_Salto > ULTIMO) ? '0 : endereco_Salto;
        end else begin
          pc_d = (pc_q >= ULTIMO) ? '0 : pc_q + UM;
        end
      end
      default: estado_d = BUSCA;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado_q <= BUSCA;
      pc_q     <= '0;
      ir_q     <= BOLHA;
      valida_q <= 1'b0;
    end else begin
      estado_q <= estado_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      valida_q <= valida_d;
    end
  end

  // valida_q is high exactly in EXECUTA, so the IR reaches the decoder for one cycle only.
  assign codigo_maquina = valida_q ? ir_q : BOLHA;
  assign instr_valida   = valida_q;
  assign endereco_rom   = pc_q;
  assign pc             = pc_q;

endmodule

// File: tb/tb_unidade_busca.sv
// tb/tb_unidade_busca.sv - directed self-checking bench for unidade_busca.
module tb_unidade_busca;

  localparam logic [16:0] BOLHA = 17'h0A000;

  logic        clock = 1'b0;
  logic        reset_n, write_pc, clear, halt, write_pc2;
  logic [5:0]  salto, salto2;
  logic [16:0] dado_rom, dado_rom2, codigo, codigo2;
  logic [5:0]  end_rom, pc, end_rom2, pc2;
  logic        valida, valida2;
`ifdef UNIDADE_BUSCA_PASSO_EN
  logic        passo;
`endif
  logic [16:0] rom [64];
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clock = ~clock;

  always @(posedge clock) begin
    dado_rom  <= rom[end_rom];
    dado_rom2 <= rom[end_rom2];
  end

  unidade_busca dut (
    .clock(clock), .reset_n(reset_n), .Write_Pc(write_pc), .endereco_Salto(salto),
    .clear(clear), .halt(halt),
`ifdef UNIDADE_BUSCA_PASSO_EN
    .passo(passo),
`endif
    .dado_rom(dado_rom), .endereco_rom(end_rom), .codigo_maquina(codigo),
    .instr_valida(valida), .pc(pc)
  );

  unidade_busca #(.ULTIMO_ENDERECO(40)) dut2 (
    .clock(clock), .reset_n(reset_n), .Write_Pc(write_pc2), .endereco_Salto(salto2),
    .clear(1'b0), .halt(1'b0),
`ifdef UNIDADE_BUSCA_PASSO_EN
    .passo(passo),
`endif
    .dado_rom(dado_rom2), .endereco_rom(end_rom2), .codigo_maquina(codigo2),
    .instr_valida(valida2), .pc(pc2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_exec();
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (valida !== 1'b1 && n < 20);
    check("wait_exec", valida, 1);
  endtask

  task automatic goto_exec(input logic [5:0] alvo);
    int k = 0;
    do begin
      wait_exec();
      k++;
    end while (pc !== alvo && k < 70);
    check("goto_pc", pc, alvo);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 17'h10000 + 17'(i * 5);
    reset_n = 1'b0; write_pc = 1'b0; clear = 1'b0; halt = 1'b0; salto = '0;
    write_pc2 = 1'b1; salto2 = 6'd45;
`ifdef UNIDADE_BUSCA_PASSO_EN
    passo = 1'b1;
`endif
    repeat (3) @(negedge clock);
    check("rst_pc", pc, 0);
    check("rst_addr", end_rom, 0);
    check("rst_codigo", codigo, BOLHA);
    check("rst_valida", valida, 0);

    reset_n = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      check("seq_valida", valida, (c % 3 == 0) ? 1 : 0);
      if (c % 3 == 0) check("seq_pc", pc, c / 3 - 1);
      if (c == 3) check("seq_codigo0", codigo, rom[0]);
      @(negedge clock);
    end
    check("seq_pc_end", pc, 3);
    check("dut2_bad_target", pc2, 0);

    salto2 = 6'd40;
    wait_exec();
    @(negedge clock);
    check("dut2_target_last", pc2, 40);
    check("pc_after3", pc, 4);
    write_pc2 = 1'b0;
    wait_exec();
    @(negedge clock);
    check("dut2_wrap40", pc2, 0);

    goto_exec(6'd5);
    write_pc = 1'b1; salto = 6'd20;
    @(negedge clock);
    write_pc = 1'b0;
    check("jump_addr", end_rom, 20);
    check("jump_valida_low", valida, 0);

    // Jump and clear held through BUSCA and CAPTURA must be ignored.
    write_pc = 1'b1; salto = 6'd7; clear = 1'b1;
    @(negedge clock);
    @(negedge clock);
    write_pc = 1'b0; clear = 1'b0;
    check("outside_valida", valida, 1);
    check("outside_pc", pc, 20);
    check("outside_codigo", codigo, rom[20]);
    @(negedge clock);
    check("outside_inc", pc, 21);

    wait_exec();
    write_pc = 1'b1; salto = 6'd63;
    @(negedge clock);
    write_pc = 1'b0;
    check("jump63", pc, 63);
    wait_exec();
    check("codigo63", codigo, rom[63]);
    @(negedge clock);
    check("wrap63", pc, 0);

    wait_exec();
    clear = 1'b1; write_pc = 1'b1; salto = 6'd9;
    @(negedge clock);
    clear = 1'b0; write_pc = 1'b0;
    check("clear_prio", pc, 0);

    halt = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("halt_codigo", codigo, BOLHA);
      check("halt_pc", pc, 0);
      check("halt_valida", valida, 0);
    end
    halt = 1'b0;
    @(negedge clock);
    halt = 1'b1;
    @(negedge clock);
    check("halt_ignored_exec", valida, 1);
    @(negedge clock);
    check("halt_ignored_pc", pc, 1);
    check("halt_ignored_busca", valida, 0);
    halt = 1'b0;

    wait_exec();
    write_pc = 1'b1; salto = 6'd12;
    @(negedge clock);
    write_pc = 1'b0;
    wait_exec();
    check("pre_reset_pc", pc, 12);
    reset_n = 1'b0;
    #1;
    check("abort_pc", pc, 0);
    check("abort_addr", end_rom, 0);
    check("abort_valida", valida, 0);
    check("abort_codigo", codigo, BOLHA);
    @(negedge clock);
    reset_n = 1'b1;
    wait_exec();
    check("refetch_pc", pc, 0);
    check("refetch_codigo", codigo, rom[0]);

`ifdef UNIDADE_BUSCA_PASSO_EN
    begin
      int cnt = 0;
      @(negedge clock);
      reset_n = 1'b0;
      passo = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
      for (int i = 0; i < 35; i++) begin
        passo = (i % 10 == 2 && i < 30);
        @(negedge clock);
        if (valida === 1'b1) cnt++;
      end
      check("passo_count", cnt, 3);
      check("passo_pc", pc, 3);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/unidade_busca.md
UNIDADE_BUSCA -- requirements
Module: unidade_busca

Interface
REQ-001 The block SHALL expose parameter LARGURA_PC, default 6, the program counter and instruction-ROM address width.
REQ-002 The block SHALL expose parameter LARGURA_INSTR, default 17, the instruction word width.
REQ-003 The block SHALL expose parameter ULTIMO_ENDERECO, default 63, the highest valid ROM address.
REQ-004 The block SHALL expose parameter BOLHA, default 17'h0A000 (CMP r0,r0), the no-write, no-jump word driven when no instruction is issued.
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-006 clock  input  1  sole clock; all state updates on its rising edge.
REQ-007 reset_n  input  1  asynchronous active-low reset.
REQ-008 Write_Pc  input  1  jump request from the decoder, sampled in EXECUTA only.
REQ-009 endereco_Salto  input  LARGURA_PC  jump target from the decoder.
REQ-010 clear  input  1  decoder reset-program request, sampled in EXECUTA only.
REQ-011 halt  input  1  stall request; freezes fetch in BUSCA.
REQ-012 dado_rom  input  LARGURA_INSTR  synchronous instruction-ROM read data, valid one cycle after the address.
REQ-013 endereco_rom  output  LARGURA_PC  instruction-ROM address, always equal to pc.
REQ-014 codigo_maquina  output  LARGURA_INSTR  instruction word to the decoder.
REQ-015 instr_valida  output  1  high exactly in EXECUTA.
REQ-016 pc  output  LARGURA_PC  current program counter.

Function
REQ-017 The FSM SHALL have states BUSCA, CAPTURA and EXECUTA, advancing BUSCA->CAPTURA->EXECUTA->BUSCA, three cycles per instruction.
REQ-018 BUSCA SHALL drive endereco_rom=pc and advance to CAPTURA only when halt=0; with halt=1 it holds, and pc and the IR stay unchanged.
REQ-019 CAPTURA SHALL load dado_rom into the internal instruction register (IR).
REQ-020 codigo_maquina SHALL equal the IR in EXECUTA and BOLHA in every other state, so each instruction reaches the decoder for exactly one cycle.
REQ-021 At the end of EXECUTA, pc SHALL update with this priority: clear=1 -> 0; else Write_Pc=1 -> endereco_Salto; else pc+1.
REQ-022 Increment from ULTIMO_ENDERECO SHALL wrap pc to 0.
REQ-023 A jump target greater than ULTIMO_ENDERECO SHALL load pc=0.
REQ-024 Simultaneous clear and Write_Pc SHALL yield pc=0.
REQ-025 halt SHALL be ignored in CAPTURA and EXECUTA; an issued instruction always completes.
REQ-026 Write_Pc and clear SHALL have no effect outside EXECUTA.

Reset
REQ-027 While reset_n=0, the block SHALL hold pc=0, endereco_rom=0, IR=BOLHA, codigo_maquina=BOLHA, instr_valida=0 and state=BUSCA.
REQ-028 Reset asserted mid-instruction, including in EXECUTA, SHALL abort the instruction immediately with no pc update.
REQ-029 After reset_n deasserts, the first fetch SHALL be from address 0.

Configuration
REQ-030 With macro UNIDADE_BUSCA_PASSO_EN defined, the block SHALL add input passo (1 bit); BUSCA then advances only on a cycle where passo=1 and halt=0 (one instruction per pulse).
REQ-031 Without UNIDADE_BUSCA_PASSO_EN, the passo port SHALL be absent and BUSCA SHALL advance whenever halt=0.

Verification
REQ-032 Reset, ROM[0..2] non-jump, halt=0 -> instr_valida high at cycles 3, 6, 9 after reset release; pc steps 0,1,2,3.
REQ-033 pc=5, EXECUTA with Write_Pc=1 and endereco_Salto=6'd20 -> next endereco_rom=20.
REQ-034 pc=63, no jump -> next pc=0; jump target 6'd63 is accepted, and ULTIMO_ENDERECO=40 with target 45 -> pc=0.
REQ-035 EXECUTA with clear=1 and Write_Pc=1 (target 9) -> pc=0; halt=1 for 5 cycles in BUSCA -> codigo_maquina=17'h0A000, pc frozen, no instr_valida.
REQ-036 reset_n pulsed low in EXECUTA at pc=12 -> outputs return to reset values at once; the next fetch is from address 0.
REQ-037 With UNIDADE_BUSCA_PASSO_EN defined, three passo pulses spaced 10 cycles apart -> exactly three instr_valida pulses and pc=3.
